// File: rtl/nlc_input_fifo_if.sv
// nlc_input_fifo_if: groups the ADC-side, NLC-side and status signals of the
// NLC input FIFO so that they can be passed around as one port.
//   adc_srdy    one-cycle strobe, adc_data is valid
//   adc_data    ADC sample
//   nlc_srdyi   one-cycle start strobe to the NLC
//   nlc_x_adc   sample presented to the NLC
//   nlc_srdyo   NLC done strobe
//   fifo_count  current occupancy, 0..DEPTH
//   busy        a sample is in flight in the NLC
//   overflow    sticky, a sample was dropped
//   err_timeout sticky, the watchdog expired
// master: the ADC/NLC/system side. slave: the FIFO itself.
interface nlc_input_fifo_if #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned PTR_W  = 3
);
  logic              adc_srdy;
  logic [DATA_W-1:0] adc_data;
  logic              nlc_srdyi;
  logic [DATA_W-1:0] nlc_x_adc;
  logic              nlc_srdyo;
  logic [PTR_W:0]    fifo_count;
  logic              busy;
  logic              overflow;
  logic              err_timeout;

  modport master (
    output adc_srdy, adc_data, nlc_srdyo,
    input  nlc_srdyi, nlc_x_adc, fifo_count, busy, overflow, err_timeout
  );

  modport slave (
    input  adc_srdy, adc_data, nlc_srdyo,
    output nlc_srdyi, nlc_x_adc, fifo_count, busy, overflow, err_timeout
  );
endinterface

// File: rtl/nlc_input_fifo.sv
// nlc_input_fifo: buffers ADC samples ahead of a single-channel NLC and issues
// them one at a time, waiting for the NLC done strobe (or a watchdog expiry)
// before issuing the next one. Dropped samples and a hung NLC are flagged
// with sticky error bits.
// Ports:
//   clk          system clock, rising edge
//   GlobalReset  synchronous active-high reset; flushes FIFO and in-flight sample
//   io_bus       nlc_input_fifo_if.slave (ADC input, NLC handshake, status)
module nlc_input_fifo #(
  parameter int unsigned DATA_W  = 21,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PTR_W   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   GlobalReset,
  nlc_input_fifo_if.slave        io_bus
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [WD_W-1:0]     r_wdog;
  logic [WD_W-1:0]     w_wdog_nxt;
  logic [DATA_W-1:0]   r_x_adc;
  logic                r_srdyi;
  logic                r_busy;
  logic                r_overflow;
  logic                r_err_timeout;
  logic                w_pop;
  logic                w_timeout;
  logic                w_full;
  logic                w_push_ok;
  logic                w_drop;

  // A full FIFO still takes a push when a pop frees a slot on the same edge.
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_push_ok = io_bus.adc_srdy && (!w_full || w_pop);
  assign w_drop    = io_bus.adc_srdy && w_full && !w_pop;

  // State register
  always_ff @(posedge clk) begin
    if (GlobalReset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next state, pop decision and watchdog
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_timeout   = 1'b0;
    w_wdog_nxt  = r_wdog;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_wdog_nxt  = WD_W'(TIMEOUT);
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done strobe during the start-strobe cycle belongs to an older sample.
        if (io_bus.nlc_srdyo && !r_srdyi) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog - WD_W'(1);
          if (r_wdog == WD_W'(1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push_ok && !GlobalReset) r_mem[r_wr_ptr] <= io_bus.adc_data;
  end

  // Pointers, occupancy, NLC outputs and sticky flags
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_wdog        <= '0;
      r_x_adc       <= '0;
      r_srdyi       <= 1'b0;
      r_busy        <= 1'b0;
      r_overflow    <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_x_adc  <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      r_wdog  <= w_wdog_nxt;
      r_srdyi <= w_pop;
      r_busy  <= (w_state_nxt == S_WAIT);
      if (w_drop)    r_overflow    <= 1'b1;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign io_bus.nlc_srdyi   = r_srdyi;
  assign io_bus.nlc_x_adc   = r_x_adc;
  assign io_bus.fifo_count  = r_count;
  assign io_bus.busy        = r_busy;
  assign io_bus.overflow    = r_overflow;
  assign io_bus.err_timeout = r_err_timeout;

endmodule

// File: tb/tb_nlc_input_fifo.sv
// Bench for nlc_input_fifo: a vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_nlc_input_fifo;

  localparam int unsigned DATA_W  = 21;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned PTR_W   = 3;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic GlobalReset;

  always #5 clk = ~clk;

  nlc_input_fifo_if #(.DATA_W(DATA_W), .PTR_W(PTR_W)) bus ();

  nlc_input_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .io_bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending samples, in-flight flag and cycles spent waiting
  logic [DATA_W-1:0] mq[$];
  logic              m_busy  = 1'b0;
  logic              m_srdyi = 1'b0;
  logic              m_ovf   = 1'b0;
  logic              m_err   = 1'b0;
  logic [DATA_W-1:0] m_x     = '0;
  int                m_n     = 0;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function void model_edge(input logic srdy, input logic [DATA_W-1:0] data,
                           input logic o, input logic rst);
    logic do_pop;
    if (rst) begin
      mq.delete();
      m_busy = 1'b0; m_srdyi = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      m_x = '0; m_n = 0;
      return;
    end
    do_pop = !m_busy && (mq.size() > 0);
    if (m_busy) begin
      if (o && !m_srdyi) m_busy = 1'b0;
      else if (m_n == int'(TIMEOUT)) begin
        m_busy = 1'b0;
        m_err  = 1'b1;
      end else m_n++;
    end
    if (do_pop) begin
      m_x    = mq.pop_front();
      m_busy = 1'b1;
      m_n    = 1;
    end
    m_srdyi = do_pop;
    if (srdy) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(data);
      else m_ovf = 1'b1;
    end
  endfunction

  function logic [31:0] dut_vec();
    return 32'({bus.nlc_srdyi, bus.nlc_x_adc, bus.fifo_count, bus.busy,
                bus.overflow, bus.err_timeout});
  endfunction

  function logic [31:0] model_vec();
    return 32'({m_srdyi, m_x, 4'(mq.size()), m_busy, m_ovf, m_err});
  endfunction

  // One clock: drive, let the edge happen, update the model, compare mid-cycle.
  task automatic step(input logic srdy, input logic [DATA_W-1:0] data,
                      input logic o, input logic rst);
    bus.adc_srdy  = srdy;
    bus.adc_data  = data;
    bus.nlc_srdyo = o;
    GlobalReset   = rst;
    @(posedge clk);
    model_edge(srdy, data, o, rst);
    @(negedge clk);
    chk("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic              srdy;
    logic [DATA_W-1:0] data;
    logic              o;
    logic              rst;
    logic              e_srdyi;
    logic [DATA_W-1:0] e_x;
    logic [3:0]        e_cnt;
    logic              e_busy;
    logic              e_ovf;
    logic              e_err;
  } vec_t;

  vec_t vt[12];

  initial begin
    int issued[$];
    int t;
    int maxc;
    int pushes;
    int k_err;
    bit done;

    bus.adc_srdy  = 1'b0;
    bus.adc_data  = '0;
    bus.nlc_srdyo = 1'b0;
    GlobalReset   = 1'b1;

    // Single-sample issue, stale done strobes, done strobes while idle
    vt[0]  = '{1'b0, 21'h0,      1'b0, 1'b1, 1'b0, 21'h0,      4'd0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 21'h0ABCDE, 1'b0, 1'b0, 1'b0, 21'h0,      4'd1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 21'h0,      1'b0, 1'b0, 1'b1, 21'h0ABCDE, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b0, 21'h0ABCDE, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 21'h0,      1'b0, 1'b0, 1'b0, 21'h0ABCDE, 4'd0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b0, 21'h0ABCDE, 4'd0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b0, 21'h0ABCDE, 4'd0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 21'h12345,  1'b1, 1'b0, 1'b0, 21'h0ABCDE, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b1, 21'h12345,  4'd0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b0, 21'h12345,  4'd0, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 21'h0,      1'b0, 1'b0, 1'b0, 21'h12345,  4'd0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{1'b0, 21'h0,      1'b1, 1'b0, 1'b0, 21'h12345,  4'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vt[i].srdy, vt[i].data, vt[i].o, vt[i].rst);
      chk($sformatf("tv%0d", i), dut_vec(),
          32'({vt[i].e_srdyi, vt[i].e_x, vt[i].e_cnt, vt[i].e_busy, vt[i].e_ovf, vt[i].e_err}));
    end

    // Eight back-to-back samples, NLC done 20 cycles after each start
    step(1'b0, '0, 1'b0, 1'b1);
    issued.delete();
    t = -1; maxc = 0; pushes = 0; done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      logic s;
      logic o;
      s = (pushes < 8);
      o = (t == 20);
      step(s, 21'(pushes + 1), o, 1'b0);
      if (s) pushes++;
      if (o) t = -1;
      if (bus.nlc_srdyi) begin
        issued.push_back(int'(bus.nlc_x_adc));
        t = 0;
      end else if (t >= 0) t++;
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
      if (issued.size() == 8 && t == -1) done = 1'b1;
    end
    chk("b2b_done", 32'(done), 32'd1);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b2b_order%0d", i), 32'((i < issued.size()) ? issued[i] : -1), 32'(i + 1));
    chk("b2b_maxcount", 32'(maxc), 32'd7);
    chk("b2b_overflow", 32'(bus.overflow), 32'd0);

    // Ten samples into a stalled NLC: drop, then watchdog
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 21'(i + 1), 1'b0, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.fifo_count), 32'd8);
    k_err = -1;
    for (int k = 10; k < 400 && k_err < 0; k++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (bus.err_timeout) k_err = k;
    end
    chk("wdog_edge", 32'(k_err), 32'd256);
    chk("wdog_busy_low", 32'(bus.busy), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("wdog_next_issue", 32'({bus.nlc_srdyi, bus.nlc_x_adc}), 32'({1'b1, 21'd2}));
    chk("ovf_sticky", 32'({bus.overflow, bus.err_timeout}), 32'b11);

    // Full FIFO: push on the same edge as an idle pop is accepted
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 21'(i + 1), 1'b0, 1'b0);
    chk("full_count", 32'(bus.fifo_count), 32'd8);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("full_idle", 32'({bus.busy, bus.fifo_count}), 32'({1'b0, 4'd8}));
    step(1'b1, 21'h1F00F, 1'b0, 1'b0);
    chk("full_pushpop", 32'({bus.nlc_srdyi, bus.nlc_x_adc, bus.fifo_count, bus.overflow}),
        32'({1'b1, 21'd2, 4'd8, 1'b0}));

    // Reset mid-operation: 3 queued, 1 in flight
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 21'(i + 100), 1'b0, 1'b0);
    chk("rst_pre", 32'({bus.busy, bus.fifo_count}), 32'({1'b1, 4'd3}));
    step(1'b0, '0, 1'b0, 1'b1);
    chk("rst_all0", dut_vec(), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("rst_srdyo_ign", dut_vec(), 32'd0);
    step(1'b1, 21'h07777, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_new_issue", 32'({bus.nlc_srdyi, bus.nlc_x_adc, bus.busy}),
        32'({1'b1, 21'h07777, 1'b1}));

    // Random traffic: moderate load, then heavy load with a slow NLC
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 2) == 0, 21'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 499) == 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 1) == 0, 21'($urandom), $urandom_range(0, 39) == 0,
           $urandom_range(0, 999) == 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
